// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the byte FIFO.
// The top and its controller both pull defaults from here.
package fifo_pkg;
  localparam int FIFO_WIDTH  = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;

  typedef logic [FIFO_WIDTH-1:0]  word_t;
  typedef logic [FIFO_ADDR_W-1:0] ptr_t;
endpackage

// File: rtl/fifo_controller.sv
// Pointer, occupancy and accept logic for the byte FIFO.
// Flags are decoded from the registered count only.
module fifo_controller
  import fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              write_en,
  input  logic              read_en,
  output logic [ADDR_W-1:0] write_pointer,
  output logic [ADDR_W-1:0] read_pointer,
  output logic              full,
  output logic              empty,
  output logic              write_strobe,
  output logic              read_strobe
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] count;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A pop frees a slot, so a write into a full FIFO is fine alongside it.
  assign read_strobe  = read_en & ~empty;
  assign write_strobe = write_en & (~full | read_strobe);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
    end else begin
      if (write_strobe)
        write_pointer <= write_pointer + 1'b1;
      if (read_strobe)
        read_pointer <= read_pointer + 1'b1;
      unique case (1'b1)
        write_strobe & ~read_strobe:
          count <= count + 1'b1;
        read_strobe & ~write_strobe:
          count <= count - 1'b1;
        default:
          count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo.sv
// Single-clock byte FIFO: storage array plus registered pop data.
// Pointer and flag bookkeeping lives in fifo_controller.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              wr_stb;
  logic              rd_stb;

  fifo_controller #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clock         (clock),
    .reset_n       (reset_n),
    .write_en      (write_en),
    .read_en       (read_en),
    .write_pointer (wptr),
    .read_pointer  (rptr),
    .full          (full),
    .empty         (empty),
    .write_strobe  (wr_stb),
    .read_strobe   (rd_stb)
  );

  // Storage is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (wr_stb)
      mem[wptr] <= data_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      data_out <= '0;
    else if (rd_stb)
      data_out <= mem[rptr];
  end

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for the byte FIFO against a queue model.
// Directed test plan sequences followed by random traffic.
module tb_fifo;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int total = 0;
  int bad = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = '0;
  bit         r_ok;
  bit         w_ok;

  fifo dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: a queue of stored words, pop before push.
  always @(posedge clock) begin
    if (reset_n) begin
      r_ok = read_en && (model_q.size() > 0);
      w_ok = write_en && ((model_q.size() < DEPTH) || r_ok);
      if (r_ok)
        exp_q.push_back(model_q.pop_front());
      if (w_ok)
        model_q.push_back(data_in);
    end
  end

  // Monitor: checks flags and popped data each cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("empty", 32'(empty), 32'(model_q.size() == 0));
      chk("full", 32'(full), 32'(model_q.size() == DEPTH));
      if (exp_q.size() > 0)
        last_exp = exp_q.pop_front();
      chk("data_out", 32'(data_out), 32'(last_exp));
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [7:0] d);
    write_en = w;
    read_en  = r;
    data_in  = d;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] fill_v[8];
    fill_v = '{8'd4, 8'd4, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1};

    @(negedge clock);
    @(negedge clock);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    reset_n = 1'b1;
    idle(1);

    // Fill, then overfill with 1s that must be dropped.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, fill_v[i]);
    chk("fill_full", 32'(full), 32'h1);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b0, 8'd1);

    // Drain with idle gaps, then the rest, then reads on empty.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      idle(2);
    end
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 8'h00);
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_last", 32'(data_out), 32'd1);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 8'h00);
    chk("empty_rd_hold", 32'(data_out), 32'd1);

    // Streaming across pointer wrap.
    cyc(1'b1, 1'b0, 8'd5);
    for (int i = 1; i < 20; i++)
      cyc(1'b1, 1'b1, 8'(5 + i / 2));
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b1, 8'h00);
    chk("stream_empty", 32'(empty), 32'h1);
    chk("stream_last", 32'(data_out), 32'd14);

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 8'(8'h10 + i));
    cyc(1'b1, 1'b1, 8'hAA);
    chk("fs_full", 32'(full), 32'h1);
    chk("fs_oldest", 32'(data_out), 32'h10);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 8'h00);
    chk("fs_last_aa", 32'(data_out), 32'hAA);

    // Asynchronous reset in the middle of activity.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b0, 8'(8'h30 + i));
    cyc(1'b0, 1'b1, 8'h00);
    write_en = 1'b0;
    read_en  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_data", 32'(data_out), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_full", 32'(full), 32'h0);
    model_q.delete();
    exp_q.delete();
    last_exp = '0;
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom));
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 8'h00);
    chk("final_empty", 32'(empty), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous FIFO. Default storage is 8 entries × 8 bits.
- It is the byte buffer between a producer and a consumer in the same clock domain. Both sides push and pop with single-cycle enables.
- It reports full and empty so that upstream and downstream logic can throttle.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- ADDR_W, log2(DEPTH) = 3, pointer width. Derived; not to be overridden.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- write_en  input  1  push request; sampled each rising edge.
- read_en  input  1  pop request; sampled each rising edge.
- data_in  input  WIDTH  word to push; sampled on an accepted write.
- data_out  output  WIDTH  registered output holding the last popped word.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-operation):
  - write pointer = 0, read pointer = 0, count = 0.
  - data_out = 0, empty = 1, full = 0.
  - Storage contents are not cleared and are don't-care.
  - Normal operation resumes on the first rising edge after reset_n goes high.
- Accepted write (write_en=1 and (full=0 or accepted read in the same cycle)):
  - mem[wptr] <= data_in.
  - wptr <= wptr+1, modulo DEPTH; wraps naturally at ADDR_W bits.
- Accepted read (read_en=1 and empty=0):
  - data_out <= mem[rptr].
  - rptr <= rptr+1, modulo DEPTH.
- Read latency: the popped word appears on data_out one clock edge after the edge at which read_en is sampled high.
- data_out holds its value when no read is accepted.
- Write while full with no simultaneous read: ignored. No storage, pointer or flag change.
- Read while empty: ignored. data_out holds, rptr unchanged.
- Simultaneous read and write:
  - Not empty and not full: both accepted; count unchanged; flags unchanged.
  - Full: both accepted; the oldest word is popped and the new word stored; full stays 1.
  - Empty: only the write is accepted. No bypass: data_out does not take data_in. Next cycle empty=0 and count=1.
- Count register, 0..DEPTH (ADDR_W+1 bits):
  - +1 on write only, −1 on read only, unchanged otherwise.
  - Never over- or underflows.
- Flags:
  - full = (count == DEPTH); empty = (count == 0).
  - Both are derived from the registered count, so they update on the same edge as the pointer change. No combinational path from write_en or read_en to the flags.
- Memory: plain register array, no reset. Read data is taken from the registered rptr.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_WIDTH=8, FIFO_DEPTH=8, FIFO_ADDR_W=3.
  - A typedef for the data word.
  - A typedef for the pointer.
- One natural sub-module, fifo_controller. It contains:
  - pointers and count;
  - full/empty generation;
  - accept logic.
- fifo_controller outputs: write_pointer, read_pointer, full, empty, and the write and read strobes. The fifo top holds the storage array and the data_out register.

Test Plan:
- Reset: pulse reset_n low for one cycle mid-simulation -> empty=1, full=0, data_out=0, and these values are reached asynchronously before the next edge.
- Fill: write_en=1 for 8 cycles with data_in = 4,4,3,3,2,2,1,1 -> empty falls after the first edge; full rises after the 8th edge. Holding write_en for 10 more cycles with data_in=1 causes no change, and a later drain yields no extra 1s.
- Drain: after fill, pulse read_en for 1 cycle, five times with idle gaps -> data_out steps 4, 4, 3, 3, 2 and holds between pops; full falls after the first pop. Keep reading -> 2, 1, 1, then empty=1. Further reads leave data_out=1.
- Read on empty: with empty=1, read_en=1 for 3 cycles -> data_out and pointers unchanged, empty stays 1.
- Streaming: from empty, write_en=1; one cycle later read_en=1. data_in increments every 2 cycles from 5 to 14. Then drop write_en; read_en stays high 6 more cycles -> data_out reproduces the written sequence in order, 5,5,6,6,… with no loss or duplication across pointer wrap. full never asserts; empty reasserts after the drain.
- Full simultaneous: with count=8, assert read_en and write_en together for one cycle with data_in=0xAA -> the oldest word appears on data_out, full stays 1, and 0xAA is the last word popped during a subsequent drain.
